cic_interpolator: RTL and testbench

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_interpolator.sv | 135 +++++++++++++
 tb/tb_cic_interpolator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : cic_interpolator
// Brief    : 3-stage CIC interpolator, R = 2**os_sel (1..128), DC gain 1.
//            Define CIC_INT_SAT_EN to clamp the output instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module cic_interpolator #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    os_sel,
  input  logic [DW-1:0] data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          underrun
);

  localparam int         IW          = DW + 21;
  localparam logic [2:0] c_valid_lat = 3'd4;

  logic                 r_loaded;
  logic [2:0]           r_ratio;
  logic [6:0]           r_phase;
  logic [2:0]           r_vcnt;
  logic                 r_ov;
  logic                 r_underrun;
  logic signed [IW-1:0] r_d1, r_d2, r_d3;
  logic signed [IW-1:0] r_up;
  logic signed [IW-1:0] r_i1, r_i2, r_i3;
  logic [DW-1:0]        r_out;

  logic [2:0]           w_ratio;
  logic [6:0]           w_last_phase;
  logic                 w_phase0;
  logic                 w_flush;
  logic                 w_ready;
  logic signed [IW-1:0] w_x, w_c1, w_c2, w_c3;
  logic [DW-1:0]        w_out;

  // Until the first edge after reset the ratio comes straight from os_sel.
  assign w_ratio      = r_loaded ? r_ratio : os_sel;
  assign w_last_phase = 7'((8'd1 << w_ratio) - 8'd1);
  assign w_phase0     = (r_phase == 7'd0);
  assign w_flush      = r_loaded && w_phase0 && (os_sel != r_ratio);
  assign w_ready      = reset_n && w_phase0 && !w_flush;

  assign w_x  = (w_ready && in_valid) ? {{(IW-DW){data_in[DW-1]}}, data_in} : '0;
  assign w_c1 = w_x  - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

`ifdef CIC_INT_SAT_EN
  localparam logic signed [IW-1:0] c_max = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] c_min = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [IW-1:0] w_shifted;

  assign w_shifted = r_i3 >>> {r_ratio, 1'b0};

  always_comb begin
    w_out = w_shifted[DW-1:0];
    if (w_shifted > c_max) begin
      w_out = c_max[DW-1:0];
    end else if (w_shifted < c_min) begin
      w_out = c_min[DW-1:0];
    end
  end
`else
  assign w_out = DW'(r_i3 >>> {r_ratio, 1'b0});
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded   <= 1'b0;
      r_ratio    <= '0;
      r_phase    <= '0;
      r_vcnt     <= '0;
      r_ov       <= 1'b0;
      r_underrun <= 1'b0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_up       <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_i3       <= '0;
      r_out      <= '0;
    end else if (w_flush) begin
      // Ratio change: drop every partial sample and restart the pipeline.
      r_ratio <= os_sel;
      r_phase <= '0;
      r_vcnt  <= '0;
      r_ov    <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_up    <= '0;
      r_i1    <= '0;
      r_i2    <= '0;
      r_i3    <= '0;
      r_out   <= '0;
    end else begin
      r_loaded <= 1'b1;
      r_ratio  <= w_ratio;
      r_phase  <= (r_phase == w_last_phase) ? 7'd0 : r_phase + 7'd1;
      if (w_ready) begin
        r_d1 <= w_x;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        if (!in_valid) begin
          r_underrun <= 1'b1;
        end
      end
      r_up  <= w_ready ? w_c3 : '0;
      r_i1  <= r_i1 + r_up;
      r_i2  <= r_i2 + r_i1;
      r_i3  <= r_i3 + r_i2;
      r_out <= w_out;
      if (r_vcnt != c_valid_lat) begin
        r_vcnt <= r_vcnt + 3'd1;
      end
      r_ov <= (r_vcnt == c_valid_lat);
    end
  end

  assign in_ready  = w_ready;
  assign data_out  = r_out;
  assign out_valid = r_ov && !w_flush;
  assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_interpolator
// Brief    : Bench for cic_interpolator; reference output is a direct
//            convolution with the CIC impulse response (box of length R)^3.
// Revision : 1.0  initial release
// ============================================================================
module tb_cic_interpolator;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    os_sel;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          underrun;

  always #5 clk = ~clk;

  cic_interpolator #(.DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_sel    (os_sel),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: ratio, cycles since (re)start, zero-stuffed input history.
  bit     m_loaded;
  int     m_sel;
  int     m_ph;
  int     m_vcnt;
  bit     m_und;
  longint m_h[$];
  longint m_x[$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void build_h(int r);
    longint a[$];
    longint b[$];
    for (int i = 0; i < r; i++) a.push_back(1);
    repeat (2) begin
      b.delete();
      for (int i = 0; i < a.size() + r - 1; i++) b.push_back(0);
      for (int i = 0; i < a.size(); i++)
        for (int j = 0; j < r; j++) b[i+j] += a[i];
      a = b;
    end
    m_h = a;
  endfunction

  function automatic logic signed [31:0] model_out();
    longint acc = 0;
    longint q;
    logic signed [15:0] t;
    for (int k = 0; k < m_h.size(); k++)
      if (4 + k < m_x.size()) acc += m_h[k] * m_x[4+k];
    q = acc >>> (2 * m_sel);
`ifdef CIC_INT_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    t = q[15:0];
    return {{16{t[15]}}, t};
  endfunction

  function automatic bit m_flush();
    return m_loaded && (m_ph == 0) && (int'(os_sel) != m_sel);
  endfunction

  function automatic bit m_ready();
    return (m_ph == 0) && !m_flush();
  endfunction

  task automatic model_reset();
    m_loaded = 0;
    m_ph     = 0;
    m_vcnt   = 0;
    m_und    = 0;
    m_x.delete();
  endtask

  task automatic reset_checks();
    chk("rst_in_ready",  in_ready,          0);
    chk("rst_data_out",  $signed(data_out), 0);
    chk("rst_out_valid", out_valid,         0);
    chk("rst_underrun",  underrun,          0);
  endtask

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic cycle();
    bit     fl;
    bit     rdy;
    longint xv;
    @(negedge clk);
    fl  = m_flush();
    rdy = m_ready();
    chk("in_ready",  in_ready,          rdy);
    chk("out_valid", out_valid,         (m_vcnt >= 5) && !fl);
    chk("underrun",  underrun,          m_und);
    chk("data_out",  $signed(data_out), model_out());
    xv = (rdy && in_valid) ? longint'($signed(data_in)) : 0;
    if (rdy && !in_valid) m_und = 1;
    if (fl) begin
      m_sel = int'(os_sel);
      build_h(1 << m_sel);
      m_x.delete();
      m_ph   = 0;
      m_vcnt = 0;
    end else begin
      if (!m_loaded) begin
        m_loaded = 1;
        m_sel    = int'(os_sel);
        build_h(1 << m_sel);
      end
      m_x.push_front(xv);
      if (m_x.size() > 400) void'(m_x.pop_back());
      m_ph = (m_ph + 1) % (1 << m_sel);
      if (m_vcnt < 5) m_vcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit     sent;
    bit     neg_seen;
    longint sum;

    reset_n  = 1'b0;
    os_sel   = 3'd0;
    data_in  = '0;
    in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset_checks();

    // R=1 ramp: bit-exact copy five cycles later
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    reset_n  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      data_in = DW'(i);
      cycle();
      if (i >= 4) chk("ramp", $signed(data_out), i - 4);
    end

    // R=2 constant 1000 (starts with a flush)
    os_sel  = 3'd1;
    data_in = DW'(1000);
    for (int i = 0; i < 40; i++) cycle();
    chk("settle_1000", $signed(data_out), 1000);

    // R=8 impulse, os_sel changed on an odd phase
    os_sel   = 3'd3;
    sent     = 0;
    sum      = 0;
    neg_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_ready() && !sent) begin
        data_in = DW'(8);
        sent    = 1;
        cycle();
      end else begin
        data_in = '0;
        cycle();
        if (sent) begin
          sum += longint'($signed(data_out));
          if (data_out[DW-1]) neg_seen = 1;
        end
      end
    end
    chk("imp_nonneg", neg_seen, 0);
    chk("imp_sum_tol", (sum >= 42) && (sum <= 86), 1);

    // R=4 random data with a forced missed sample
    os_sel = 3'd2;
    for (int i = 0; i < 80; i++) begin
      data_in  = DW'($urandom);
      in_valid = !(m_ready() && i >= 16 && i < 20) && ($urandom_range(0, 7) != 0);
      cycle();
    end
    in_valid = 1'b1;
    chk("underrun_sticky", underrun, 1);
    chk("out_valid_kept", out_valid, 1);

    // R=8 step to full scale
    os_sel   = 3'd3;
    data_in  = '0;
    neg_seen = 0;
    for (int i = 0; i < 20; i++) cycle();
    data_in = DW'(32767);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (data_out[DW-1]) neg_seen = 1;
    end
    chk("step_nonneg", neg_seen, 0);
    chk("step_settle", $signed(data_out), 32767);

    // random ratios, data and valid
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) os_sel = 3'($urandom_range(0, 7));
      data_in  = DW'($urandom);
      in_valid = ($urandom_range(0, 15) != 0);
      cycle();
    end

    // asynchronous reset mid-stream
    #2;
    reset_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    os_sel   = 3'd1;
    in_valid = 1'b1;
    reset_n  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      data_in = DW'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
